// File: rtl/organsynth_axil_pkg.sv
// OrganSynth AXI4-Lite register bank: shared types.
// Response codes, channel FSM states and address decode helper.
package organsynth_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  // Byte address to word index; sub-word address bits are dropped.
  function automatic int unsigned word_index(
    input logic [31:0] addr,
    input int unsigned data_width
  );
    if (data_width == 64) begin
      return 32'(addr >> 3);
    end
    return 32'(addr >> 2);
  endfunction

endpackage

// File: rtl/organsynth_axil_rd_chan.sv
// OrganSynth AXI4-Lite register bank: read channel.
// AR/R handshake FSM with registered read mux over ctrl and status words.
module organsynth_axil_rd_chan
  import organsynth_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_RW     = 8,
  parameter int NUM_RO     = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        araddr,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [1:0]                   rresp,
  output logic                         rvalid,
  input  logic                         rready,
  input  logic [NUM_RW*DATA_WIDTH-1:0] ctrl_regs,
  input  logic [NUM_RO*DATA_WIDTH-1:0] status_regs,
  output logic [NUM_RO-1:0]            status_rd_pulse
);

  rd_state_t             rd_state;
  int unsigned           rd_idx;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [1:0]            sel_resp;
  logic [NUM_RO-1:0]     sel_ro;
  logic                  ar_hs;

  assign ar_hs  = arvalid & arready;
  assign rd_idx = word_index(32'(araddr), DATA_WIDTH);

  // Decode the requested word: ctrl, status, or unmapped.
  always_comb begin
    sel_data = '0;
    sel_resp = RESP_SLVERR;
    sel_ro   = '0;
    for (int unsigned k = 0; k < NUM_RW; k++) begin
      if (rd_idx == k) begin
        sel_data = ctrl_regs[k*DATA_WIDTH +: DATA_WIDTH];
        sel_resp = RESP_OKAY;
      end
    end
    for (int unsigned j = 0; j < NUM_RO; j++) begin
      if (rd_idx == NUM_RW + j) begin
        sel_data  = status_regs[j*DATA_WIDTH +: DATA_WIDTH];
        sel_resp  = RESP_OKAY;
        sel_ro[j] = 1'b1;
      end
    end
  end

  // AR/R FSM; data is captured on the AR edge and held until rready.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state        <= RD_IDLE;
      arready         <= 1'b0;
      rvalid          <= 1'b0;
      rdata           <= '0;
      rresp           <= RESP_OKAY;
      status_rd_pulse <= '0;
    end else begin
      status_rd_pulse <= '0;
      unique case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            rdata           <= sel_data;
            rresp           <= sel_resp;
            rvalid          <= 1'b1;
            arready         <= 1'b0;
            status_rd_pulse <= sel_ro;
            rd_state        <= RD_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        RD_DATA: begin
          if (rready) begin
            rvalid   <= 1'b0;
            arready  <= 1'b1;
            rd_state <= RD_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/organsynth_axil_regbank.sv
// OrganSynth AXI4-Lite register bank: top level.
// Write FSM, ctrl register storage, and the read channel instance.
module organsynth_axil_regbank
  import organsynth_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_RW     = 8,
  parameter int NUM_RO     = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic [2:0]                   s_axi_awprot,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [DATA_WIDTH-1:0]        s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]      s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [2:0]                   s_axi_arprot,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [NUM_RW*DATA_WIDTH-1:0] ctrl_regs,
  output logic [NUM_RW-1:0]            ctrl_wr_pulse,
  input  logic [NUM_RO*DATA_WIDTH-1:0] status_regs,
  output logic [NUM_RO-1:0]            status_rd_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;

  wr_state_t             wr_state;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic [DATA_WIDTH-1:0] ctrl_q [NUM_RW];
  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic                  wr_hit;
  int unsigned           wr_idx;
  logic                  unused_prot;

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid & s_axi_wready;
  assign wr_idx = word_index(32'(aw_addr_q), DATA_WIDTH);
  assign wr_hit = wr_idx < unsigned'(NUM_RW);
  assign commit = (wr_state == WR_RESP) & ~s_axi_bvalid;

  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  // Latch AW and W independently; WR_RESP covers commit and B wait.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state      <= WR_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
    end else begin
      if (aw_hs) begin
        aw_addr_q <= s_axi_awaddr;
      end
      if (w_hs) begin
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      unique case (wr_state)
        WR_IDLE: begin
          if (aw_hs && w_hs) begin
            wr_state      <= WR_RESP;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
          end else if (aw_hs) begin
            wr_state      <= WR_HAVE_AW;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
          end else if (w_hs) begin
            wr_state      <= WR_HAVE_W;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
          end else begin
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
          end
        end
        WR_HAVE_AW: begin
          if (w_hs) begin
            wr_state     <= WR_RESP;
            s_axi_wready <= 1'b0;
          end
        end
        WR_HAVE_W: begin
          if (aw_hs) begin
            wr_state      <= WR_RESP;
            s_axi_awready <= 1'b0;
          end
        end
        WR_RESP: begin
          if (!s_axi_bvalid) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
          end else if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            wr_state      <= WR_IDLE;
          end
        end
      endcase
    end
  end

  // Byte-lane merge into the addressed ctrl register at commit.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_RW; k++) begin
        ctrl_q[k] <= '0;
      end
      ctrl_wr_pulse <= '0;
    end else begin
      ctrl_wr_pulse <= '0;
      if (commit && wr_hit) begin
        for (int unsigned k = 0; k < NUM_RW; k++) begin
          if (wr_idx == k) begin
            ctrl_wr_pulse[k] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (w_strb_q[b]) begin
                ctrl_q[k][b*8 +: 8] <= w_data_q[b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_flat
    assign ctrl_regs[g*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[g];
  end

  organsynth_axil_rd_chan #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_RW     (NUM_RW),
    .NUM_RO     (NUM_RO)
  ) u_rd_chan (
    .clock           (clock),
    .reset           (reset),
    .araddr          (s_axi_araddr),
    .arvalid         (s_axi_arvalid),
    .arready         (s_axi_arready),
    .rdata           (s_axi_rdata),
    .rresp           (s_axi_rresp),
    .rvalid          (s_axi_rvalid),
    .rready          (s_axi_rready),
    .ctrl_regs       (ctrl_regs),
    .status_regs     (status_regs),
    .status_rd_pulse (status_rd_pulse)
  );

endmodule

// File: tb/tb_organsynth_axil_regbank.sv
// OrganSynth AXI4-Lite register bank: testbench.
// Scoreboard of expected B/R responses plus pulse counters.
module tb_organsynth_axil_regbank;
  import organsynth_axil_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int NRW = 8;
  localparam int NRO = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [AW-1:0] awaddr = '0;
  logic [2:0] awprot = '0;
  logic awvalid = 1'b0;
  logic awready;
  logic [DW-1:0] wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic wvalid = 1'b0;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic [2:0] arprot = '0;
  logic arvalid = 1'b0;
  logic arready;
  logic [DW-1:0] rdata;
  logic [1:0] rresp;
  logic rvalid;
  logic rready = 1'b0;
  logic [NRW*DW-1:0] ctrl_regs;
  logic [NRW-1:0] ctrl_wr_pulse;
  logic [NRO*DW-1:0] status_regs;
  logic [NRO-1:0] status_rd_pulse;

  logic [DW-1:0] status_w [NRO];
  logic [DW-1:0] model [NRW];
  int exp_wp [NRW] = '{default: 0};
  int got_wp [NRW] = '{default: 0};
  int exp_rp [NRO] = '{default: 0};
  int got_rp [NRO] = '{default: 0};
  logic [1:0] bq [$];
  logic [33:0] rq [$];
  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NRO; g++) begin : g_st
    assign status_regs[g*DW +: DW] = status_w[g];
  end

  organsynth_axil_regbank #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_RW     (NRW),
    .NUM_RO     (NRO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .s_axi_awaddr    (awaddr),
    .s_axi_awprot    (awprot),
    .s_axi_awvalid   (awvalid),
    .s_axi_awready   (awready),
    .s_axi_wdata     (wdata),
    .s_axi_wstrb     (wstrb),
    .s_axi_wvalid    (wvalid),
    .s_axi_wready    (wready),
    .s_axi_bresp     (bresp),
    .s_axi_bvalid    (bvalid),
    .s_axi_bready    (bready),
    .s_axi_araddr    (araddr),
    .s_axi_arprot    (arprot),
    .s_axi_arvalid   (arvalid),
    .s_axi_arready   (arready),
    .s_axi_rdata     (rdata),
    .s_axi_rresp     (rresp),
    .s_axi_rvalid    (rvalid),
    .s_axi_rready    (rready),
    .ctrl_regs       (ctrl_regs),
    .ctrl_wr_pulse   (ctrl_wr_pulse),
    .status_regs     (status_regs),
    .status_rd_pulse (status_rd_pulse)
  );

  // Count high cycles of every pulse line.
  always @(negedge clock) begin
    for (int k = 0; k < NRW; k++) if (ctrl_wr_pulse[k]) got_wp[k]++;
    for (int j = 0; j < NRO; j++) if (status_rd_pulse[j]) got_rp[j]++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] creg(input int k);
    return ctrl_regs[k*DW +: DW];
  endfunction

  task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s);
    int k;
    k = int'(a >> 2);
    if (k < NRW) begin
      bq.push_back(RESP_OKAY);
      for (int b = 0; b < 4; b++) if (s[b]) model[k][b*8 +: 8] = d[b*8 +: 8];
      exp_wp[k]++;
    end else begin
      bq.push_back(RESP_SLVERR);
    end
  endtask

  task automatic send_aw_w(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [3:0] s);
    logic ar, wr_;
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      ar = awready; wr_ = wready;
      tick();
      if (ar) awvalid = 1'b0;
      if (wr_) wvalid = 1'b0;
      n++;
    end
    if (awvalid || wvalid) begin
      chk("aw_w_timeout", 1, 0);
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic take_b();
    int n;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    if (!bvalid) chk("b_timeout", 0, 1);
    else if (bq.size() == 0) chk("bq_underflow", 1, 0);
    else begin
      chk("bresp", bresp, bq.pop_front());
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("b_drop", bvalid, 0);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [3:0] s);
    push_write(a, d, s);
    send_aw_w(a, d, s);
    take_b();
  endtask

  task automatic push_read(input logic [AW-1:0] a);
    int k;
    k = int'(a >> 2);
    if (k < NRW) rq.push_back({RESP_OKAY, model[k]});
    else if (k < NRW + NRO) begin
      rq.push_back({RESP_OKAY, status_w[k-NRW]});
      exp_rp[k-NRW]++;
    end else rq.push_back({RESP_SLVERR, 32'h0});
  endtask

  task automatic send_ar(input logic [AW-1:0] a);
    logic r;
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 50) begin
      r = arready;
      tick();
      if (r) arvalid = 1'b0;
      n++;
    end
    if (arvalid) begin
      chk("ar_timeout", 1, 0);
      arvalid = 1'b0;
    end
  endtask

  task automatic take_r();
    logic [33:0] e;
    int n;
    n = 0;
    while (!rvalid && n < 50) begin tick(); n++; end
    if (!rvalid) chk("r_timeout", 0, 1);
    else if (rq.size() == 0) chk("rq_underflow", 1, 0);
    else begin
      e = rq.pop_front();
      chk("rresp", rresp, e[33:32]);
      chk("rdata", rdata, e[31:0]);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk("r_drop", rvalid, 0);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a);
    push_read(a);
    send_ar(a);
    take_r();
  endtask

  initial begin
    logic hs;
    int n;
    int pw;
    for (int k = 0; k < NRW; k++) model[k] = '0;
    status_w[0] = 32'hDEADBEEF;
    status_w[1] = 32'h00C0FFEE;
    status_w[2] = 32'h5A5A0002;
    status_w[3] = 32'hCAFE0003;

    // reset state
    tick(); tick();
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_ctrl", ctrl_regs, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", {bresp, rresp}, 0);
    chk("rst_pulse", {ctrl_wr_pulse, status_rd_pulse}, 0);
    reset = 1'b0;
    tick();
    chk("rdy_after_rst", {awready, wready, arready}, 3'b111);

    // sequential write / readback
    for (int i = 0; i < NRW; i++) wr(AW'(i*4), DW'(i+1), 4'hF);
    for (int i = 0; i < NRW; i++) rd(AW'(i*4));
    for (int k = 0; k < NRW; k++) chk("seq_pulse", got_wp[k], 1);

    // W before AW
    push_write(6'h08, 32'h12345678, 4'hF);
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    n = 0; hs = 1'b0;
    while (!hs && n < 50) begin hs = wready; tick(); n++; end
    wvalid = 1'b0;
    chk("wfirst_w_hs", hs, 1);
    repeat (3) begin
      tick();
      chk("wfirst_wait", {awready, wready, bvalid}, 3'b100);
    end
    awaddr = 6'h08; awvalid = 1'b1;
    n = 0; hs = 1'b0;
    while (!hs && n < 50) begin hs = awready; tick(); n++; end
    awvalid = 1'b0;
    chk("wfirst_pre", {bvalid, ctrl_wr_pulse[2]}, 2'b00);
    tick();
    chk("wfirst_commit", {bvalid, ctrl_wr_pulse[2]}, 2'b11);
    chk("wfirst_reg2", creg(2), 32'h12345678);
    take_b();

    // byte strobes
    wr(6'h04, 32'h11223344, 4'hF);
    wr(6'h04, 32'hFFFFFFFF, 4'b0101);
    chk("strb_reg1", creg(1), 32'h11FF33FF);
    rd(6'h04);
    wr(6'h04, 32'h00000000, 4'h0);
    chk("strb_zero", creg(1), 32'h11FF33FF);

    // RO and out of range
    wr(6'h20, 32'h55555555, 4'hF);
    wr(6'h3C, 32'h66666666, 4'hF);
    for (int k = 0; k < NRW; k++) chk("slverr_regs", creg(k), model[k]);
    rd(6'h20);
    rd(6'h2C);
    rd(6'h30);
    rd(6'h1C);
    for (int j = 0; j < NRO; j++) chk("rd_pulse", got_rp[j], exp_rp[j]);

    // write backpressure, second AW held off
    push_write(6'h0C, 32'hAAAA0000, 4'hF);
    send_aw_w(6'h0C, 32'hAAAA0000, 4'hF);
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    push_write(6'h10, 32'h0BADF00D, 4'hF);
    awaddr = 6'h10; awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {bvalid, awready, wready}, 3'b100);
      tick();
    end
    chk("bp_bresp", bresp, bq.pop_front());
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bp_rdy_back", {bvalid, awready, wready}, 3'b011);
    send_aw_w(6'h10, 32'h0BADF00D, 4'hF);
    take_b();
    chk("bp_reg3", creg(3), 32'hAAAA0000);
    chk("bp_reg4", creg(4), 32'h0BADF00D);

    // read backpressure
    push_read(6'h0C);
    send_ar(6'h0C);
    n = 0;
    while (!rvalid && n < 50) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      chk("rbp_hold", {rvalid, arready}, 2'b10);
      chk("rbp_data", rdata, 32'hAAAA0000);
      tick();
    end
    take_r();
    chk("rbp_arready", arready, 1);

    // reset mid-write
    awaddr = 6'h04; awvalid = 1'b1;
    n = 0; hs = 1'b0;
    while (!hs && n < 50) begin hs = awready; tick(); n++; end
    awvalid = 1'b0;
    pw = got_wp[1];
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < NRW; k++) model[k] = '0;
    tick(); tick();
    chk("mid_rst_reg1", creg(1), 0);
    chk("mid_rst_bvalid", bvalid, 0);
    chk("mid_rst_pulse", got_wp[1], pw);
    wr(6'h04, 32'hA5A5A5A5, 4'hF);
    rd(6'h04);
    chk("post_rst_reg1", creg(1), 32'hA5A5A5A5);

    for (int k = 0; k < NRW; k++) chk("wp_total", got_wp[k], exp_wp[k]);
    for (int j = 0; j < NRO; j++) chk("rp_total", got_rp[j], exp_rp[j]);
    chk("queues_empty", bq.size() + rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
